// File: rtl/common_pkg.sv
// -----------------------------------------------------------------------------
// common -- shared bus types for the core memory interfaces.
//
// Contents:
//   msize_t / MSIZE*   : transfer size encodings (1, 2, 4, 8 bytes)
//   mlen_t  / MLEN*    : burst length encodings (beats - 1)
//   ibus_req_t/resp_t  : instruction fetch bus (32-bit data)
//   dbus_req_t/resp_t  : data bus (64-bit data, byte strobes)
//   cbus_req_t/resp_t  : shared memory bus toward the interconnect
// -----------------------------------------------------------------------------
package common;

    typedef logic [2:0] msize_t;
    localparam msize_t MSIZE1 = 3'b000;
    localparam msize_t MSIZE2 = 3'b001;
    localparam msize_t MSIZE4 = 3'b010;
    localparam msize_t MSIZE8 = 3'b011;

    typedef logic [3:0] mlen_t;
    localparam mlen_t MLEN1  = 4'b0000;
    localparam mlen_t MLEN2  = 4'b0001;
    localparam mlen_t MLEN4  = 4'b0011;
    localparam mlen_t MLEN8  = 4'b0111;
    localparam mlen_t MLEN16 = 4'b1111;

    typedef logic [63:0] addr_t;
    typedef logic [7:0]  strobe_t;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        addr_t       addr;
        msize_t      size;
        strobe_t     strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        addr_t       addr;
        strobe_t     strobe;
        logic [63:0] data;
        mlen_t       len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter.sv
// -----------------------------------------------------------------------------
// cbus_arbiter -- shares one cbus between the fetch (ibus) and data (dbus)
// ports with at most one transaction in flight.
//
// Parameters:
//   D_FIRST : side preferred on simultaneous requests after reset (1 = dbus)
// Ports:
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-low reset
//   ireq  / iresp : fetch request in / fetch response out
//   dreq  / dresp : data request in / data response out
//   oreq  / oresp : shared bus request out / shared bus response in
// -----------------------------------------------------------------------------
module cbus_arbiter
    import common::*;
#(
    parameter bit D_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t    r_state;
    cbus_req_t r_hold;
    logic      r_last_d;   // 1 when the most recent grant went to dbus

    logic      w_any;
    logic      w_pick_d;
    logic      w_done;
    cbus_req_t w_ireq_x;
    cbus_req_t w_dreq_x;

    assign w_any = ireq.valid | dreq.valid;

    // dbus wins when it is alone, or when both ask and ibus was served last.
    assign w_pick_d = dreq.valid & (~ireq.valid | ~r_last_d);

    assign w_done = (r_state != IDLE) & oresp.ready & oresp.last;

    // Request translation into cbus form; only consumed when latching.
    always_comb begin
        w_ireq_x          = '0;
        w_ireq_x.valid    = 1'b1;
        w_ireq_x.is_write = 1'b0;
        w_ireq_x.size     = MSIZE4;
        w_ireq_x.addr     = ireq.addr;
        w_ireq_x.strobe   = '0;
        w_ireq_x.data     = '0;
        w_ireq_x.len      = MLEN1;
    end

    always_comb begin
        w_dreq_x          = '0;
        w_dreq_x.valid    = 1'b1;
        w_dreq_x.is_write = |dreq.strobe;
        w_dreq_x.size     = dreq.size;
        w_dreq_x.addr     = dreq.addr;
        w_dreq_x.strobe   = dreq.strobe;
        w_dreq_x.data     = dreq.data;
        w_dreq_x.len      = MLEN1;
    end

    // The last-grant flag resets to the opposite of the preferred side so
    // the preferred side wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_hold   <= '0;
            r_last_d <= ~D_FIRST;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state  <= w_pick_d ? BUSY_D : BUSY_I;
                        r_last_d <= w_pick_d;
                        r_hold   <= w_pick_d ? w_dreq_x : w_ireq_x;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (w_done) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outgoing request comes only from the hold register; valid follows state
    // so an asynchronous reset drops it at once.
    always_comb begin
        oreq       = r_hold;
        oreq.valid = (r_state != IDLE);
    end

    // Fetch data picks the 32-bit half selected by the latched address.
    always_comb begin
        iresp         = '0;
        iresp.addr_ok = (r_state == BUSY_I) & w_done;
        iresp.data_ok = (r_state == BUSY_I) & w_done;
        iresp.data    = r_hold.addr[2] ? oresp.data[63:32] : oresp.data[31:0];
    end

    always_comb begin
        dresp         = '0;
        dresp.addr_ok = (r_state == BUSY_D) & w_done;
        dresp.data_ok = (r_state == BUSY_D) & w_done;
        dresp.data    = oresp.data;
    end

endmodule
